// File: rtl/next_pc_unit.sv
// Next-PC selection: sequential, branch, jump, call and return,
// with a small return-address stack and a one-cycle flush pulse.
module next_pc_unit #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_cur,
  input  logic [AW-1:0] pc_pls1,
  input  logic          stall,
  input  logic          br_taken,
  input  logic          jump,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] target,
  input  logic          err_clr,
  output logic [AW-1:0] pc_next,
  output logic          flush,
  output logic          stk_full,
  output logic          stk_empty,
  output logic          err_ovf,
  output logic          err_unf
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] L_FULL  = PW'(DEPTH);
  localparam logic [PW-1:0] L_INC   = PW'(1);
  localparam logic [PW-2:0] L_ONE   = (PW-1)'(1);

  logic [AW-1:0] r_stk [DEPTH];
  logic [PW-1:0] r_ptr;
  logic          r_flush;
  logic          r_ovf;
  logic          r_unf;

  logic [PW-2:0] w_top_idx;
  logic [AW-1:0] w_top;
  logic          w_full;
  logic          w_empty;
  logic [AW-1:0] w_pc_next;
  logic          w_redir;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf;
  logic          w_unf;

  assign w_full    = (r_ptr == L_FULL);
  assign w_empty   = (r_ptr == '0);
  assign w_top_idx = r_ptr[PW-2:0] - L_ONE;
  assign w_top     = r_stk[w_top_idx];

  always_comb begin
    w_pc_next = pc_pls1;
    w_redir   = 1'b0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf     = 1'b0;
    w_unf     = 1'b0;
    priority case (1'b1)
      stall: w_pc_next = pc_cur;
      ret: begin
        if (w_empty) begin
          w_unf = 1'b1;
        end else begin
          w_pc_next = w_top;
          w_pop     = 1'b1;
          w_redir   = 1'b1;
        end
      end
      call: begin
        w_pc_next = target;
        w_redir   = 1'b1;
        w_push    = !w_full;
        w_ovf     = w_full;
      end
      jump, br_taken: begin
        w_pc_next = target;
        w_redir   = 1'b1;
      end
      default: w_pc_next = pc_pls1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr   <= '0;
      r_flush <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_flush <= w_redir;
      if (w_push)
        r_ptr <= r_ptr + L_INC;
      else if (w_pop)
        r_ptr <= r_ptr - L_INC;
      // a new error in the same cycle beats err_clr
      r_ovf <= w_ovf | (r_ovf & ~err_clr);
      r_unf <= w_unf | (r_unf & ~err_clr);
    end
  end

  // entries are not reset; the pointer alone defines what is live
  always_ff @(posedge clk) begin
    if (w_push && rst)
      r_stk[r_ptr[PW-2:0]] <= pc_pls1;
  end

  assign pc_next   = w_pc_next;
  assign flush     = r_flush;
  assign stk_full  = w_full;
  assign stk_empty = w_empty;
  assign err_ovf   = r_ovf;
  assign err_unf   = r_unf;

endmodule

// File: tb/tb_next_pc_unit.sv
// Bench for next_pc_unit: directed vectors, literal checks and
// a queue-based reference model compared on every falling edge.
module tb_next_pc_unit;

  localparam int DEPTH = 4;

  localparam logic [4:0] R_NONE  = 5'b00000;
  localparam logic [4:0] R_STALL = 5'b10000;
  localparam logic [4:0] R_RET   = 5'b01000;
  localparam logic [4:0] R_CALL  = 5'b00100;
  localparam logic [4:0] R_JMP   = 5'b00010;
  localparam logic [4:0] R_BR    = 5'b00001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pc_cur = 8'h00;
  logic [7:0] pc_pls1 = 8'h01;
  logic       stall = 1'b0;
  logic       br_taken = 1'b0;
  logic       jump = 1'b0;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic [7:0] target = 8'h00;
  logic       err_clr = 1'b0;
  logic [7:0] pc_next;
  logic       flush;
  logic       stk_full;
  logic       stk_empty;
  logic       err_ovf;
  logic       err_unf;

  next_pc_unit #(.AW(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pc_cur(pc_cur), .pc_pls1(pc_pls1),
    .stall(stall), .br_taken(br_taken),
    .jump(jump), .call(call), .ret(ret),
    .target(target), .err_clr(err_clr),
    .pc_next(pc_next), .flush(flush),
    .stk_full(stk_full), .stk_empty(stk_empty),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  logic [7:0] m_q[$];
  bit m_flush = 1'b0;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_pc();
    if (stall) return pc_cur;
    if (ret) return (m_q.size() > 0) ? m_q[$] : pc_pls1;
    if (call || jump || br_taken) return target;
    return pc_pls1;
  endfunction

  always @(posedge clk or negedge rst) begin
    bit sov, sun, rd;
    if (!rst) begin
      m_q.delete();
      m_flush = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      sov = 1'b0;
      sun = 1'b0;
      rd = 1'b0;
      if (!stall) begin
        if (ret) begin
          if (m_q.size() > 0) begin
            void'(m_q.pop_back());
            rd = 1'b1;
          end else sun = 1'b1;
        end else if (call) begin
          rd = 1'b1;
          if (m_q.size() < DEPTH) m_q.push_back(pc_pls1);
          else sov = 1'b1;
        end else if (jump || br_taken) rd = 1'b1;
      end
      m_flush = rd;
      m_ovf = sov | (m_ovf & !err_clr);
      m_unf = sun | (m_unf & !err_clr);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_pc_next", pc_next, exp_pc());
      chk("m_flush", {7'd0, flush}, {7'd0, m_flush});
      chk("m_full", {7'd0, stk_full},
          {7'd0, m_q.size() == DEPTH});
      chk("m_empty", {7'd0, stk_empty},
          {7'd0, m_q.size() == 0});
      chk("m_ovf", {7'd0, err_ovf}, {7'd0, m_ovf});
      chk("m_unf", {7'd0, err_unf}, {7'd0, m_unf});
    end
  end

  task automatic drive(input logic [7:0] cur,
                       input logic [4:0] req,
                       input logic [7:0] tgt);
    pc_cur = cur;
    pc_pls1 = cur + 8'd1;
    {stall, ret, call, jump, br_taken} = req;
    target = tgt;
    err_clr = 1'b0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_empty", {7'd0, stk_empty}, 8'd1);
    chk("rst_full", {7'd0, stk_full}, 8'd0);
    chk("rst_flush", {7'd0, flush}, 8'd0);
    chk("rst_ovf", {7'd0, err_ovf}, 8'd0);
    chk("rst_unf", {7'd0, err_unf}, 8'd0);
    chk("rst_pc", pc_next, 8'h01);
    chk_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;

    drive(8'h10, R_NONE, 8'h00);
    chk("seq_pc", pc_next, 8'h11);
    tick();
    chk("seq_flush", {7'd0, flush}, 8'd0);

    drive(8'h20, R_CALL, 8'h80);
    chk("call1_pc", pc_next, 8'h80);
    tick();
    chk("call1_flush", {7'd0, flush}, 8'd1);
    drive(8'h30, R_CALL, 8'h90);
    chk("call2_pc", pc_next, 8'h90);
    tick();
    drive(8'h40, R_CALL, 8'hA0);
    chk("call3_pc", pc_next, 8'hA0);
    tick();
    chk("nest_notfull", {7'd0, stk_full}, 8'd0);
    drive(8'hA0, R_RET, 8'h00);
    chk("ret1_pc", pc_next, 8'h41);
    tick();
    chk("ret1_flush", {7'd0, flush}, 8'd1);
    drive(8'h90, R_RET, 8'h00);
    chk("ret2_pc", pc_next, 8'h31);
    tick();
    drive(8'h80, R_RET, 8'h00);
    chk("ret3_pc", pc_next, 8'h21);
    tick();
    chk("nest_empty", {7'd0, stk_empty}, 8'd1);
    drive(8'h21, R_NONE, 8'h00);
    tick();
    chk("nest_flush0", {7'd0, flush}, 8'd0);

    drive(8'h20, R_CALL, 8'h80);
    tick();
    drive(8'h30, R_CALL, 8'h90);
    tick();
    chk("pre_rst_full", {7'd0, stk_empty}, 8'd0);
    chk("pre_rst_flush", {7'd0, flush}, 8'd1);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_empty", {7'd0, stk_empty}, 8'd1);
    chk("mid_rst_flush", {7'd0, flush}, 8'd0);
    chk("mid_rst_pc", pc_next, 8'h90);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 1; i <= 4; i++) begin
      drive(8'(i), R_CALL, 8'(8'hE0 + i));
      tick();
    end
    chk("ovf_full", {7'd0, stk_full}, 8'd1);
    chk("ovf_pre", {7'd0, err_ovf}, 8'd0);
    drive(8'h05, R_CALL, 8'hE5);
    chk("ovf_pc", pc_next, 8'hE5);
    tick();
    chk("ovf_set", {7'd0, err_ovf}, 8'd1);
    chk("ovf_flush", {7'd0, flush}, 8'd1);
    drive(8'hE5, R_RET, 8'h00);
    chk("ovf_pop", pc_next, 8'h05);
    tick();
    drive(8'h05, R_NONE, 8'h00);
    err_clr = 1'b1;
    tick();
    chk("ovf_clr", {7'd0, err_ovf}, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      drive(8'h60, R_RET, 8'h00);
      chk("drain_pc", pc_next, 8'(8'h05 - k));
      tick();
    end
    chk("drain_empty", {7'd0, stk_empty}, 8'd1);

    drive(8'h45, R_RET, 8'h00);
    chk("unf_pc", pc_next, 8'h46);
    tick();
    chk("unf_set", {7'd0, err_unf}, 8'd1);
    chk("unf_flush", {7'd0, flush}, 8'd0);
    chk("unf_empty", {7'd0, stk_empty}, 8'd1);

    drive(8'h50, R_CALL | R_JMP | R_BR, 8'h5C);
    chk("prio_pc", pc_next, 8'h5C);
    tick();
    chk("prio_push", {7'd0, stk_empty}, 8'd0);
    drive(8'h5C, R_STALL | R_RET, 8'h00);
    chk("stall_pc", pc_next, 8'h5C);
    tick();
    chk("stall_flush", {7'd0, flush}, 8'd0);
    chk("stall_keep", {7'd0, stk_empty}, 8'd0);
    drive(8'h5C, R_RET, 8'h00);
    chk("prio_ret", pc_next, 8'h51);
    tick();
    chk("prio_empty", {7'd0, stk_empty}, 8'd1);

    drive(8'hFF, R_CALL, 8'h10);
    chk("wrap_call", pc_next, 8'h10);
    tick();
    drive(8'h10, R_RET, 8'h00);
    chk("wrap_ret", pc_next, 8'h00);
    tick();
    drive(8'h00, R_NONE, 8'h00);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
